rr_ring_arbiter: RTL and testbench
==================================

// Module: rr_ring_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among N_REQ requesters.
//  Priority pointer is a one-hot ring counter that rotates past each served requester.
//  Grant is held while the owner keeps requesting, up to MAX_HOLD cycles, then forcibly released.
//  Sits between requester blocks and a shared datapath/bus in lab designs.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  MAX_HOLD  8   max consecutive cycles one grant may be held (>=1)
//  CNT_W     $clog2(MAX_HOLD+1)  hold-counter width (derived, localparam)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       reset, asynchronous, active-high
//  en        in   1       1 = new grants allowed; 0 = no new grant issued (held grant unaffected)
//  req       in   N_REQ   level requests, req[i] high while requester i wants resource
//  grant     out  N_REQ   registered one-hot grant (all-zero when idle)
//  grant_id  out  $clog2(N_REQ)  binary index of current owner; 0 when idle
//  busy      out  1       1 while any grant bit set
//  timeout   out  1       one-cycle pulse on forced release after MAX_HOLD
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, hold_cnt=0, ptr=one-hot bit0.
//  FSM states: IDLE, GRANT.
//  IDLE: if en && |req -> pick first set req[i] scanning from ptr upward with wrap (ptr itself highest);
//   grant[i]=1, busy=1, hold_cnt=1 on next edge (1-cycle req->grant latency); else stay.
//  GRANT: owner = set bit of grant.
//   req[owner]==0 -> release: next edge grant=0, busy=0, ptr=rotate-left(grant), -> IDLE.
//   req[owner]==1 && hold_cnt==MAX_HOLD -> forced release: same as release, timeout=1 for that cycle.
//   else hold_cnt++, grant unchanged.
//  Release always costs one idle cycle (grant=0) before the next grant; no back-to-back grants.
//  Owner drop and hold limit in same cycle -> normal release, timeout=0.
//  Non-owner req changes during GRANT ignored; en ignored in GRANT.
//  ptr rotation wraps: bit N_REQ-1 -> bit0. ptr always exactly one-hot; never all-zero.
//  req=0 in IDLE -> ptr unchanged.
//  Reset asserted mid-grant -> grant drops immediately (async), ptr returns to bit0.
//  grant is always one-hot or zero; assertion in bench.
// STRUCTURE
//  Package rr_arb_pkg: typedef enum logic {IDLE, GRANT} arb_state_t; function rotl1 (one-hot rotate).
//  Sub-module rr_ring_ptr: N_REQ-bit one-hot ring register, async preset to bit0, advance input
//   loads rotate-left of supplied one-hot vector. Top holds FSM, priority scan, hold counter.
// TESTING (N_REQ=4, MAX_HOLD=8)
//  Reset: rst=1 -> grant=0000, busy=0, timeout=0, ptr=0001.
//  req=1111 held, owners drop after 2 cycles each -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//  ptr=0001, req=0100 only -> grant=0100, grant_id=2 next edge; drop -> ptr=1000.
//  req0 held 12 cycles, req1=1 -> grant 0001 for 8 cycles, timeout pulse, idle cycle, grant 0010.
//  en=0 with req=0011 -> grant stays 0000; en=1 -> grant 0001 next edge.
//  Grant 0100 active, rst pulsed mid-cycle -> grant 0000 immediately, next grant from ptr=0001.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// rotl1 rotates a one-hot vector left by one inside an n-bit ring held in a wider container.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int unsigned MAX_REQ = 32;

    typedef logic [MAX_REQ-1:0] ring_vec_t;

    function automatic ring_vec_t rotl1(input ring_vec_t v, input int unsigned n);
        ring_vec_t one;
        ring_vec_t top;
        ring_vec_t r;
        one = ring_vec_t'(1);
        top = one << (n - 1);
        // Shift up, drop anything pushed past the ring, then wrap the top bit to bit0.
        r = (v << 1) & ~(one << n);
        if ((v & top) != '0) begin
            r = r | one;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_ring_ptr.sv
// One-hot priority ring register; presets to bit0 and loads the rotate-left of vec on advance.
module rr_ring_ptr
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic [N_REQ-1:0] vec,
    output logic [N_REQ-1:0] ptr
);

    logic [N_REQ-1:0] ptr_d;
    logic [N_REQ-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = N_REQ'(rotl1(ring_vec_t'(vec), N_REQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= N_REQ'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with one-hot rotating priority and a bounded grant hold time.
// Every release costs one idle cycle before the next grant is issued.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned SUM_W = IDX_W + 1;

    arb_state_t       state_d, state_q;
    logic [N_REQ-1:0] grant_d, grant_q;
    logic [IDX_W-1:0] id_d, id_q;
    logic             busy_d, busy_q;
    logic             timeout_d, timeout_q;
    logic [CNT_W-1:0] hold_d, hold_q;

    logic [N_REQ-1:0] ptr;
    logic             ptr_adv;

    logic [IDX_W-1:0] ptr_idx;
    logic [N_REQ-1:0] req_rot;
    logic [SUM_W-1:0] pick_sum;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;

    rr_ring_ptr #(
        .N_REQ (N_REQ)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (ptr_adv),
        .vec     (grant_q),
        .ptr     (ptr)
    );

    // Rotate requests so the pointer position lands on bit0, find the first set bit,
    // then map that offset back to an absolute requester index.
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ptr[i]) begin
                ptr_idx = IDX_W'(i);
            end
        end

        req_rot    = N_REQ'({req, req} >> ptr_idx);
        pick_sum   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = SUM_W'(k) + {1'b0, ptr_idx};
            end
        end
        if (pick_sum >= SUM_W'(N_REQ)) begin
            pick_sum = pick_sum - SUM_W'(N_REQ);
        end
        pick_idx = IDX_W'(pick_sum);
    end

    assign owner_req = |(req & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        ptr_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && pick_found) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << pick_idx;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req || (hold_q == CNT_W'(MAX_HOLD))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    id_d      = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    ptr_adv   = 1'b1;
                    // A voluntary drop wins over the hold limit.
                    timeout_d = owner_req;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter: directed scenarios plus random traffic,
// compared every cycle against an owner/pointer/hold-count reference model.
module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 idle), cycles held, priority index, timeout pulse.
    int m_owner;
    int m_hold;
    int m_ptr;
    int m_to;

    logic [N-1:0] prev_grant;
    int           grant_log[$];

    rr_ring_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_to    = 0;
    endtask

    // Advance the model by one clock edge using the currently driven en/req.
    task automatic model_step();
        m_to = 0;
        if (m_owner < 0) begin
            if (en && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (m_owner < 0 && req[i]) begin
                        m_owner = i;
                        m_hold  = 1;
                    end
                end
            end
        end else if (!req[m_owner] || m_hold == MAX_HOLD) begin
            m_to    = req[m_owner] ? 1 : 0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_hold  = 0;
        end else begin
            m_hold++;
        end
    endtask

    task automatic compare();
        logic [31:0] exp_grant;
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        check("grant", 32'(grant), exp_grant);
        check("grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check("timeout", 32'(timeout), 32'(m_to));
        check("ptr", 32'(dut.u_ptr.ptr_q), 32'd1 << m_ptr);
        check("onehot0", $onehot0(grant) ? 32'd1 : 32'd0, 32'd1);
        if (grant != '0 && prev_grant == '0) begin
            grant_log.push_back(int'(grant));
        end
        prev_grant = grant;
    endtask

    task automatic cycle(input logic e, input logic [N-1:0] r);
        @(negedge clk);
        compare();
        en  = e;
        req = r;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare();
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        model_reset();
        #1;
        compare();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        rst        = 1'b1;
        en         = 1'b0;
        req        = '0;
        prev_grant = '0;
        model_reset();
        @(negedge clk);
        compare();
        #1;
        rst = 1'b0;

        // Everyone requesting, each owner drops after two granted cycles.
        for (int c = 0; c < 40; c++) begin
            r = '1;
            if (m_owner >= 0 && m_hold >= 2) begin
                r = r & ~(4'b0001 << m_owner);
            end
            cycle(1'b1, r);
        end
        cycle(1'b1, '0);
        check("order_len", (grant_log.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) begin
                check("order", 32'(grant_log[i]), 32'd1 << (i % N));
            end
        end

        // Single requester away from the pointer.
        do_reset();
        cycle(1'b1, 4'b0100);
        cycle(1'b1, 4'b0100);
        check("single_id", 32'(grant_id), 32'd2);
        cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b0000);
        check("single_ptr", 32'(dut.u_ptr.ptr_q), 32'b1000);

        // Hold limit forces release, then the other requester is served.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(1'b1, 4'b0011);
        end

        // en low blocks new grants.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 4'b0011);
        end
        cycle(1'b1, 4'b0011);
        cycle(1'b1, 4'b0011);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cycle(1'b1, 4'b0100);
        cycle(1'b1, 4'b0100);
        @(negedge clk);
        compare();
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_grant", 32'(grant), 32'd0);
        model_reset();
        compare();
        #1;
        rst = 1'b0;
        en  = 1'b1;
        req = 4'b0101;
        model_step();
        cycle(1'b1, 4'b0101);
        check("post_rst_grant", 32'(grant), 32'b0001);

        // Random sticky traffic with occasional en drops.
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    r = r ^ (4'b0001 << i);
                end
            end
            cycle(($urandom_range(0, 7) != 0), r);
        end

        @(negedge clk);
        compare();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
